ps2_keyboard: RTL
=================

// Module: ps2_keyboard
// PURPOSE
//  PS/2 keyboard receiver. It feeds the I/O bus keyboard port at 0xf0000014 (scancode) and 0xf0000018 (KBDready).
//  It deserialises 11-bit PS/2 device-to-host frames, checks odd parity and buffers bytes in a FIFO.
//  It presents the FIFO head to the bus and pops one byte per KBDread handshake.
// PARAMETERS
//  FIFO_DEPTH      8       scancode FIFO entries; power of 2, >=2
//  FILTER_LEN      8       consecutive equal clk samples before filtered ps2_clk changes level
//  TIMEOUT_CYCLES  100000  clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  ps2_clk    in   1  PS/2 clock pin (asynchronous)
//  ps2_data   in   1  PS/2 data pin (asynchronous)
//  KBDread    in   1  bus read-acknowledge level; held high by the bus until KBDready falls
//  KBDready   out  1  FIFO non-empty and a byte is on offer
//  scancode   out  8  FIFO head byte; 8'h00 when FIFO empty
//  overflow   out  1  sticky: a byte was dropped because the FIFO was full; cleared only by rst
//  frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset: all registers clear asynchronously.
//   - Outputs: KBDready=0, scancode=0, overflow=0, frame_err=0.
//   - Internal: FSM=IDLE, FIFO empty, filter settled high.
//   - Reset mid-frame discards the partial frame.
//  Input conditioning:
//   - Each pin passes a 2-FF synchroniser.
//   - Filtered ps2_clk toggles only after FILTER_LEN equal samples.
//   - A filtered 1->0 transition (fall) samples synced ps2_data.
//  FSM (advances only on a fall, except on timeout):
//   - IDLE: data=0 -> DATA with bitcnt=0. Data=1 is a bad start: stay in IDLE, no error.
//   - DATA: shift in LSB-first (shreg <= {d, shreg[7:1]}). After the 8th bit -> PARITY.
//   - PARITY: latch p. ok = ^{shreg,p} == 1 (odd). -> STOP.
//   - STOP: d=1 and ok -> push shreg. Otherwise frame_err pulse and no push. Always -> IDLE.
//   - Timeout: in any state except IDLE, TIMEOUT_CYCLES clk with no fall -> IDLE, frame_err pulse. The watchdog counter reloads on every fall.
//  FIFO:
//   - Push happens in the cycle after the stop-bit fall is detected.
//   - Push while full (and no pop in the same cycle) drops the byte and sets overflow.
//   - Push and pop in the same cycle are both performed; a push while full is accepted if a pop occurs that cycle.
//   - Pointers are log2(FIFO_DEPTH) bits and wrap mod depth; count is log2(FIFO_DEPTH)+1 bits.
//  Read handshake:
//   - hs_busy is set on a KBDread rising edge (KBDread=1, previous sample 0) while KBDready=1. That edge pops one entry.
//   - KBDready = !empty && !hs_busy, registered: it falls the cycle after the pop.
//   - hs_busy clears when KBDread is sampled 0. KBDready may reassert the following cycle if the FIFO is still non-empty.
//   - A KBDread high while KBDready=0 never pops.
//   - scancode tracks the head combinationally from FIFO storage. It is stable while KBDready=1.
//  Latency:
//   - Stop-bit fall to KBDready=1 (FIFO previously empty, idle handshake) is 3 clk.
//   - Total is fall detect + push + ready register, excluding synchroniser and filter delay.
// STRUCTURE
//  Shared package/header (kbd_defs):
//   - FSM state encodings (IDLE, DATA, PARITY, STOP).
//   - Bus address constants KBD_SCANCODE_ADDR=32'hf0000014 and KBD_READY_ADDR=32'hf0000018.
//  Sub-module kbd_fifo:
//   - Synchronous FIFO, parameter DEPTH.
//   - Ports: push, pop, din, dout, empty, full.
//  Top level holds the synchronisers, filter, FSM, watchdog and handshake.
// TESTING
//  Bench models the PS/2 device at a ~12.5 kHz clock. Parameters use FILTER_LEN=8 and TIMEOUT_CYCLES=2000 for speed.
//  1. Frame 0x1C with parity 0 -> KBDready=1 and scancode=8'h1C.
//     KBDread=1 -> KBDready=0 the next clk. KBDread=0 -> KBDready stays 0 and FIFO empty.
//  2. Frames 0xF0 then 0x1C back-to-back with no reads -> scancode=0xF0 first.
//     After one full handshake, KBDready reasserts with scancode=0x1C; a second handshake empties the FIFO.
//  3. Frame 0x1C with parity bit 1 -> exactly one frame_err pulse, KBDready stays 0, nothing pushed.
//  4. Nine valid frames 0x01..0x09 with no reads at depth 8 -> overflow=1.
//     Reads return 0x01..0x08 and 0x09 is lost. overflow stays 1 until rst.
//  5. Four data bits, then the line held idle for more than 2000 clk -> frame_err pulse and FSM back in IDLE.
//     A following frame 0x5A is received correctly.
//  6. A 3-clk low glitch on ps2_clk -> no FSM advance.
//     rst asserted mid-frame -> all outputs 0, and the next frame 0x29 is received correctly.

Source files
------------

// File: rtl/kbd_defs.sv
// Shared definitions for the PS/2 keyboard port: receiver FSM states and
// the bus addresses at which the keyboard registers are decoded.
package kbd_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kbd_state_e;

  localparam logic [31:0] KBD_SCANCODE_ADDR = 32'hf000_0014;
  localparam logic [31:0] KBD_READY_ADDR    = 32'hf000_0018;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scancode FIFO. A push while full is accepted only when a pop
// frees an entry in the same cycle; otherwise the byte is ignored here.
module kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: pin conditioning, frame FSM with watchdog, and a
// scancode FIFO read through a level-based KBDread/KBDready handshake.
module ps2_keyboard
  import kbd_defs::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       KBDread,
  output logic       KBDready,
  output logic [7:0] scancode,
  output logic       overflow,
  output logic       frame_err,
  output kbd_state_e state_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronisers reset high so an idle bus produces no edge after reset.
  logic [1:0] pclk_s_q;
  logic [1:0] pdat_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s_q <= 2'b11;
      pdat_s_q <= 2'b11;
    end else begin
      pclk_s_q <= {pclk_s_q[0], ps2_clk};
      pdat_s_q <= {pdat_s_q[0], ps2_data};
    end
  end

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (pclk_s_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = pclk_s_q[1];
        fall_d = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
    end
  end

  kbd_state_e    state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          ok_q;
  logic          push_q;
  logic          err_q;
  logic [TW-1:0] wd_q;
  logic          din;

  assign din = pdat_s_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ok_q     <= 1'b0;
      push_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      push_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == ST_IDLE || fall_q) wd_q <= '0;
      else                              wd_q <= wd_q + TW'(1);

      if (state_q != ST_IDLE && !fall_q && wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
      end else if (fall_q) begin
        case (state_q)
          ST_IDLE: begin
            // A high start bit is treated as line noise, not a frame error.
            if (!din) begin
              state_q  <= ST_DATA;
              bitcnt_q <= '0;
            end
          end
          ST_DATA: begin
            shreg_q  <= {din, shreg_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            ok_q    <= parity_ok(shreg_q, din);
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (din && ok_q) push_q <= 1'b1;
            else             err_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_dout;
  logic       pop;
  logic       rd_prev_q;
  logic       busy_q, busy_d;
  logic       ready_q;
  logic       ovf_q;

  // Only a rising KBDread edge while a byte is on offer pops; the bus then
  // holds KBDread high until it sees KBDready fall.
  assign pop    = KBDread && !rd_prev_q && ready_q;
  assign busy_d = pop ? 1'b1 : (KBDread ? busy_q : 1'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rd_prev_q <= KBDread;
      busy_q    <= busy_d;
      ready_q   <= !fifo_empty && !busy_d;
      if (push_q && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .din   (shreg_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign KBDready  = ready_q;
  assign scancode  = fifo_empty ? 8'h00 : fifo_dout;
  assign overflow  = ovf_q;
  assign frame_err = err_q;
  assign state_o   = state_q;

endmodule
